// File: rtl/contador_pkg.sv
// Shared constants, readout state encoding and popcount helper for the
// parametrised word counters.
package contador_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 8;
    // Widest channel vector the popcount helper accepts.
    localparam int MAX_CH    = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READ    = 2'd2
    } estado_t;

    // Number of set bits; narrower vectors are zero-extended by the caller.
    function automatic logic [5:0] popcount(input logic [MAX_CH-1:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/contador_canal.sv
// One counter slot: a live counter that adds a variable amount per cycle
// (wrapping or saturating) plus a snapshot register loaded on a capture strobe.
// snap_nxt_o exposes the value the snapshot holds after this edge, which lets
// the readout bypass the capture cycle.
module contador_canal #(
    parameter int CNT_W    = 8,
    parameter int INC_W    = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    input  logic             cap,
    output logic [CNT_W-1:0] snap_nxt_o
);

    localparam int SUM_W = CNT_W + INC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] snap_q;
    logic [CNT_W-1:0] snap_d;
    logic [SUM_W-1:0] sum_d;

    // Next live value: clear beats counting; the wide sum detects overflow.
    always_comb begin
        sum_d = {{INC_W{1'b0}}, cnt_q} + {{CNT_W{1'b0}}, inc};
        if (!en) begin
            cnt_d = cnt_q;
        end else if (clr) begin
            cnt_d = '0;
        end else if ((SATURATE != 0) && (sum_d > {{INC_W{1'b0}}, CNT_MAX})) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = sum_d[CNT_W-1:0];
        end
    end

    // Snapshot takes the post-increment live value so same-cycle pops are included.
    always_comb begin
        if (en && cap) begin
            snap_d = cnt_d;
        end else begin
            snap_d = snap_q;
        end
    end

    assign snap_nxt_o = snap_d;

    // Live counter and snapshot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

endmodule

// File: rtl/contador_palabras_param.sv
// Per-channel popped-word counters plus a total, read out through a req/idx
// handshake from an atomic snapshot so the total matches the channel sum.
module contador_palabras_param
    import contador_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int IDX_W    = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Enable,
    input  logic             init,
    input  logic [N_CH-1:0]  pop,
    input  logic [N_CH-1:0]  fifo_empty,
    input  logic             req,
    input  logic [IDX_W-1:0] idx,
    output logic [CNT_W-1:0] data_out,
    output logic             valid
);

    localparam int INC_W = $clog2(N_CH + 1);

    logic [N_CH-1:0]  ev_d;
    logic             cap_d;
    logic             idx_ok_d;
    logic [CNT_W-1:0] sel_d;
    logic [INC_W-1:0] inc_d  [N_CH+1];
    logic [CNT_W-1:0] snap_d [N_CH+1];

    logic             req_q;
    estado_t          state_q;
    logic [CNT_W-1:0] data_out_q;
    logic             valid_q;

    // A pop only counts when the FIFO actually had a word to give.
    assign ev_d     = Enable ? (pop & ~fifo_empty) : '0;
    assign cap_d    = Enable && req && !req_q;
    assign idx_ok_d = (idx <= IDX_W'(N_CH));

    // Increment amounts: one bit per channel, popcount for the total slot.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            inc_d[i] = INC_W'(ev_d[i]);
        end
        inc_d[N_CH] = INC_W'(popcount(MAX_CH'(ev_d)));
    end

    for (genvar g = 0; g <= N_CH; g++) begin : g_canal
        contador_canal #(
            .CNT_W    (CNT_W),
            .INC_W    (INC_W),
            .SATURATE (SATURATE)
        ) u_canal (
            .clk        (clk),
            .reset      (reset),
            .en         (Enable),
            .clr        (init),
            .inc        (inc_d[g]),
            .cap        (cap_d),
            .snap_nxt_o (snap_d[g])
        );
    end

    // Select the addressed snapshot slot; out-of-range reads yield zero.
    always_comb begin
        sel_d = '0;
        for (int i = 0; i <= N_CH; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_d = snap_d[i];
            end
        end
    end

    // Readout FSM, request edge tracking and registered data/valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else if (Enable) begin
            req_q <= req;
            case (state_q)
                IDLE:    state_q <= req ? CAPTURE : IDLE;
                CAPTURE: state_q <= req ? READ : IDLE;
                READ:    state_q <= req ? READ : IDLE;
                default: state_q <= IDLE;
            endcase
            if (init) begin
                valid_q <= 1'b0;
            end else if (req && idx_ok_d) begin
                data_out_q <= sel_d;
                valid_q    <= 1'b1;
            end else if (req) begin
                data_out_q <= '0;
                valid_q    <= 1'b0;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;

endmodule
